hash_load_ctrl: RTL and testbench
=================================

Name: hash_load_ctrl

Overview:
- Sequencer between the USB receive byte stream and the block-header buffer that feeds the hashing core.
- Parses token and data packets and qualifies OUT/IN tokens against the device address.
- Steers two DATA payload chunks (63 B via DATA0+HASH meta, then 49 B via DATA1) into a 112-byte header buffer, then hands the completed block to the miner.
- Raises interrupt and protocol-error events.

Parameters:
- DEV_ADDR, 7'h15, device address compared against the token address byte [6:0].
- CHUNK1_LEN, 63, header bytes carried by the DATA0/HASH packet.
- CHUNK2_LEN, 49, header bytes carried by the DATA1 packet.
- ADDR_W, 7, header buffer address width.

Ports:
- clk  in  1  system clock
- n_rst  in  1  synchronous active-low reset
- byte_valid  in  1  one-cycle strobe, rx_byte is valid
- rx_byte  in  8  received byte
- eop  in  1  end-of-packet strobe (never coincident with byte_valid)
- rcv_error  in  1  receiver error strobe
- block_ack  in  1  consumer has taken the header
- buf_wr_en  out  1  header buffer write strobe
- buf_wr_addr  out  ADDR_W  header buffer byte address
- buf_wr_data  out  8  header buffer byte
- new_block  out  1  level; header complete, held until block_ack
- interrupt_req  out  1  one-cycle pulse
- in_token  out  1  one-cycle pulse, valid IN token
- p_error  out  1  one-cycle pulse, protocol error

Behaviour:
- Reset (n_rst low at a clk edge): state IDLE; out_armed=0; chunk1_done=0; all outputs 0. Reset mid-packet discards everything.
- Byte counter cnt (7 b) clears on each packet's PID byte and increments on every subsequent byte_valid.
- PIDs: OUT=E1, IN=69, DATA0=C3, DATA1=4B. Meta bytes: INTERRUPT=04, HASH=01.
- IDLE, first byte_valid:
  - OUT or IN -> TOK_ADDR.
  - DATA0 with out_armed -> DATA_META.
  - DATA1 with out_armed and chunk1_done -> PAY2.
  - DATA0/DATA1 otherwise -> DISCARD plus p_error at eop.
  - Any other PID -> DISCARD silently.
- TOK_ADDR: byte -> match = (byte[6:0]==DEV_ADDR); go to TOK_ENDP.
- TOK_ENDP: byte -> TOK_EOP.
- TOK_EOP, on eop with match:
  - OUT -> out_armed=1.
  - IN -> in_token pulse next cycle.
  - No match -> ignored. Return to IDLE.
  - Extra byte in TOK_EOP -> DISCARD, token ignored.
- DATA_META:
  - 04 -> INT_WAIT.
  - 01 with new_block=0 -> PAY1.
  - 01 with new_block=1 -> DISCARD plus p_error.
  - Other -> DISCARD plus p_error.
- INT_WAIT: eop after exactly 2 further bytes (CRC) -> interrupt_req pulse. Otherwise p_error.
- PAY1: payload index k = cnt-2 (meta excluded).
  - For k < CHUNK1_LEN: buf_wr_en=1, addr=k, data=byte, one cycle after byte_valid.
  - Later bytes (CRC) are not written.
  - eop with exactly CHUNK1_LEN+2 payload-phase bytes -> chunk1_done=1. Else p_error, chunk1_done=0.
- PAY2: k = cnt-1.
  - k < CHUNK2_LEN writes to addr CHUNK1_LEN+k (63..111).
  - eop with exactly CHUNK2_LEN+2 bytes -> new_block=1 the cycle after eop; chunk1_done=0. Else p_error, chunk1_done=0.
- Any DATA packet accepted or discarded clears out_armed at its eop.
- DISCARD: wait for eop -> IDLE.
- eop in any non-IDLE state -> IDLE. Short token packets -> IDLE silently. Short data packets -> p_error.
- eop in IDLE: ignored.
- rcv_error in any state: p_error next cycle; out_armed=0, chunk1_done=0; state DISCARD, or IDLE if already IDLE. A partially written buffer is never flagged.
- new_block: cleared the cycle after block_ack. block_ack in the same cycle new_block would set -> new_block stays 0. block_ack while new_block=0 is ignored.
- Writes during PAY2 never occur while new_block=1; the HASH rejection guarantees this.
- Pulse outputs are mutually exclusive per cycle. Outputs are registered; latency from input strobe to output is one cycle.

Test Plan:
1. Reset, then IN token 69,15,xx, eop -> in_token pulse 1 cycle after eop. Same token with addr 16 -> no pulse.
2. OUT 15 token, then DATA0,04,c1,c2, eop -> interrupt_req single pulse, no buf writes, out_armed cleared.
3. OUT token, DATA0,01, 63 header bytes, 2 CRC, eop -> 63 writes addr 0..62 in order with exact data, no new_block. Then OUT, DATA1, 49 bytes, 2 CRC, eop -> writes addr 63..111, new_block=1 next cycle. block_ack -> new_block=0.
4. DATA1 chunk without a preceding chunk1, and DATA0 without an OUT token -> p_error at eop, zero writes, new_block stays 0.
5. With new_block held, OUT+DATA0/01 -> p_error, no writes. Chunk2 with 48 bytes + CRC -> p_error, chunk1_done cleared, new_block not set.
6. rcv_error mid-PAY1 at byte 20 -> p_error next cycle, remaining bytes unwritten. n_rst low mid-PAY2 -> all outputs 0 next cycle, a following DATA1 rejected.

Source files
------------

// File: rtl/hash_load_ctrl.sv
// Receive-side sequencer: parses USB token/data packets and steers two DATA
// payload chunks into the 112-byte block-header buffer for the hashing core.
module hash_load_ctrl #(
    parameter logic [6:0] DEV_ADDR   = 7'h15,
    parameter int         CHUNK1_LEN = 63,
    parameter int         CHUNK2_LEN = 49,
    parameter int         ADDR_W     = 7
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              byte_valid,
    input  logic [7:0]        rx_byte,
    input  logic              eop,
    input  logic              rcv_error,
    input  logic              block_ack,
    output logic              buf_wr_en,
    output logic [ADDR_W-1:0] buf_wr_addr,
    output logic [7:0]        buf_wr_data,
    output logic              new_block,
    output logic              interrupt_req,
    output logic              in_token,
    output logic              p_error,
    output logic [3:0]        state_dbg
);
    // Handshake: byte_valid, eop and rcv_error are single-cycle strobes with no
    // backpressure; new_block is a level held until the consumer pulses block_ack.

    typedef enum logic [3:0] {
        IDLE, TOK_ADDR, TOK_ENDP, TOK_EOP, DATA_META, INT_WAIT, PAY1, PAY2, DISCARD
    } state_t;

    localparam logic [7:0] PID_OUT   = 8'hE1;
    localparam logic [7:0] PID_IN    = 8'h69;
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;
    localparam logic [7:0] META_INT  = 8'h04;
    localparam logic [7:0] META_HASH = 8'h01;

    // cnt holds the index of the last byte received (PID = 0).
    localparam logic [6:0] C1     = 7'(CHUNK1_LEN);
    localparam logic [6:0] C2     = 7'(CHUNK2_LEN);
    localparam logic [6:0] C1_END = 7'(CHUNK1_LEN + 3);
    localparam logic [6:0] C2_END = 7'(CHUNK2_LEN + 2);
    localparam logic [6:0] INT_END = 7'd3;

    state_t     state;
    logic [6:0] cnt;
    logic       is_in;
    logic       is_data;
    logic       tok_match;
    logic       disc_err;
    logic       out_armed;
    logic       chunk1_done;

    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state         <= IDLE;
            cnt           <= '0;
            is_in         <= 1'b0;
            is_data       <= 1'b0;
            tok_match     <= 1'b0;
            disc_err      <= 1'b0;
            out_armed     <= 1'b0;
            chunk1_done   <= 1'b0;
            buf_wr_en     <= 1'b0;
            buf_wr_addr   <= '0;
            buf_wr_data   <= '0;
            new_block     <= 1'b0;
            interrupt_req <= 1'b0;
            in_token      <= 1'b0;
            p_error       <= 1'b0;
        end else begin
            buf_wr_en     <= 1'b0;
            interrupt_req <= 1'b0;
            in_token      <= 1'b0;
            p_error       <= 1'b0;
            if (new_block && block_ack)
                new_block <= 1'b0;

            if (rcv_error) begin
                p_error     <= 1'b1;
                out_armed   <= 1'b0;
                chunk1_done <= 1'b0;
                disc_err    <= 1'b0;
                state       <= (state == IDLE) ? IDLE : DISCARD;
            end else if (byte_valid) begin
                // Saturate so an over-long packet can never alias a valid length.
                if (state == IDLE)
                    cnt <= '0;
                else if (cnt != 7'h7F)
                    cnt <= cnt + 7'd1;
                case (state)
                    IDLE: begin
                        is_data  <= 1'b0;
                        disc_err <= 1'b0;
                        case (rx_byte)
                            PID_OUT: begin is_in <= 1'b0; state <= TOK_ADDR; end
                            PID_IN:  begin is_in <= 1'b1; state <= TOK_ADDR; end
                            PID_DATA0: begin
                                is_data <= 1'b1;
                                if (out_armed) state <= DATA_META;
                                else begin state <= DISCARD; disc_err <= 1'b1; end
                            end
                            PID_DATA1: begin
                                is_data <= 1'b1;
                                if (out_armed && chunk1_done) state <= PAY2;
                                else begin state <= DISCARD; disc_err <= 1'b1; end
                            end
                            default: state <= DISCARD;
                        endcase
                    end
                    TOK_ADDR: begin
                        tok_match <= (rx_byte[6:0] == DEV_ADDR);
                        state     <= TOK_ENDP;
                    end
                    TOK_ENDP: state <= TOK_EOP;
                    TOK_EOP:  state <= DISCARD;
                    DATA_META: begin
                        if (rx_byte == META_INT)
                            state <= INT_WAIT;
                        else if (rx_byte == META_HASH && !new_block)
                            state <= PAY1;
                        else begin
                            state    <= DISCARD;
                            disc_err <= 1'b1;
                        end
                    end
                    PAY1: begin
                        if (cnt <= C1) begin
                            buf_wr_en   <= 1'b1;
                            buf_wr_addr <= ADDR_W'(cnt - 7'd1);
                            buf_wr_data <= rx_byte;
                        end
                    end
                    PAY2: begin
                        if (cnt < C2) begin
                            buf_wr_en   <= 1'b1;
                            buf_wr_addr <= ADDR_W'(C1 + cnt);
                            buf_wr_data <= rx_byte;
                        end
                    end
                    default: ;
                endcase
            end else if (eop && state != IDLE) begin
                state <= IDLE;
                if (is_data)
                    out_armed <= 1'b0;
                case (state)
                    TOK_EOP: begin
                        if (tok_match) begin
                            if (is_in) in_token  <= 1'b1;
                            else       out_armed <= 1'b1;
                        end
                    end
                    DATA_META: p_error <= 1'b1;
                    INT_WAIT: begin
                        if (cnt == INT_END) interrupt_req <= 1'b1;
                        else                p_error       <= 1'b1;
                    end
                    PAY1: begin
                        chunk1_done <= (cnt == C1_END);
                        if (cnt != C1_END) p_error <= 1'b1;
                    end
                    PAY2: begin
                        chunk1_done <= 1'b0;
                        if (cnt != C2_END) p_error <= 1'b1;
                        else if (!block_ack) new_block <= 1'b1;
                    end
                    DISCARD: if (disc_err) p_error <= 1'b1;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_hash_load_ctrl.sv
// Directed bench for hash_load_ctrl: token qualification, interrupt packets,
// two-chunk header loads, protocol errors, rcv_error and reset mid-packet.
module tb_hash_load_ctrl;
    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       byte_valid = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       eop = 1'b0;
    logic       rcv_error = 1'b0;
    logic       block_ack = 1'b0;
    logic       buf_wr_en;
    logic [6:0] buf_wr_addr;
    logic [7:0] buf_wr_data;
    logic       new_block;
    logic       interrupt_req;
    logic       in_token;
    logic       p_error;
    logic [3:0] state_dbg;

    hash_load_ctrl dut (
        .clk(clk), .n_rst(n_rst), .byte_valid(byte_valid), .rx_byte(rx_byte),
        .eop(eop), .rcv_error(rcv_error), .block_ack(block_ack),
        .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
        .new_block(new_block), .interrupt_req(interrupt_req), .in_token(in_token),
        .p_error(p_error), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // monitor: log writes and pulses on the falling edge
    logic [14:0] obs_q[$];
    int n_in = 0, n_int = 0, n_perr = 0, n_excl = 0;
    always @(negedge clk) begin
        if (buf_wr_en) obs_q.push_back({buf_wr_addr, buf_wr_data});
        if (in_token) n_in++;
        if (interrupt_req) n_int++;
        if (p_error) n_perr++;
        if (int'(in_token) + int'(interrupt_req) + int'(p_error) > 1) n_excl++;
    end

    // scoreboard
    logic [14:0] exp_q[$];
    int rd_ptr = 0;
    int b_in, b_int, b_perr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        byte_valid = 1'b1;
        rx_byte    = b;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic send_eop();
        @(negedge clk);
        eop = 1'b1;
        @(negedge clk);
        eop = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic token(input logic [7:0] pid, input logic [6:0] addr);
        send_byte(pid);
        send_byte({1'b0, addr});
        send_byte(8'h5A);
        send_eop();
    endtask

    function automatic logic [7:0] hdr(input int k);
        return 8'((k * 37) + 5);
    endfunction

    task automatic snap();
        b_in = n_in; b_int = n_int; b_perr = n_perr;
    endtask

    // payload bytes at header positions [first, first+n), optionally logged as expected
    task automatic send_hdr(input int first, input int n, input bit expect_wr);
        for (int k = first; k < first + n; k++) begin
            send_byte(hdr(k));
            if (expect_wr) exp_q.push_back({7'(k), hdr(k)});
        end
    endtask

    task automatic check_writes(input string tag);
        idle(2);
        chk({tag, "_count"}, obs_q.size() - rd_ptr, exp_q.size());
        while (exp_q.size() > 0 && rd_ptr < obs_q.size()) begin
            logic [14:0] e;
            e = exp_q.pop_front();
            chk({tag, "_entry"}, obs_q[rd_ptr], e);
            rd_ptr++;
        end
        exp_q.delete();
        rd_ptr = obs_q.size();
    endtask

    task automatic chunk1_full();
        token(8'hE1, 7'h15);
        send_byte(8'hC3);
        send_byte(8'h01);
        send_hdr(0, 63, 1'b1);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_eop();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outputs", {buf_wr_en, new_block, interrupt_req, in_token, p_error}, 5'b0);
        n_rst = 1'b1;
        idle(2);

        // IN token to our address, then to another
        snap();
        token(8'h69, 7'h15);
        chk("in_tok_latency", in_token, 1'b1);
        idle(1);
        chk("in_tok_single", in_token, 1'b0);
        token(8'h69, 7'h16);
        idle(2);
        chk("in_tok_count", n_in - b_in, 1);

        // interrupt packet; out_armed must clear afterwards
        snap();
        token(8'hE1, 7'h15);
        send_byte(8'hC3); send_byte(8'h04); send_byte(8'hC1); send_byte(8'hC2);
        send_eop();
        chk("int_latency", interrupt_req, 1'b1);
        idle(2);
        chk("int_count", n_int - b_int, 1);
        send_byte(8'hC3); send_byte(8'h04); send_byte(8'hC1); send_byte(8'hC2);
        send_eop();
        idle(2);
        chk("int_unarmed_count", n_int - b_int, 1);
        chk("int_unarmed_perr", n_perr - b_perr, 1);
        check_writes("int_writes");

        // full two-chunk header load
        snap();
        chunk1_full();
        check_writes("chunk1");
        chk("chunk1_no_block", new_block, 1'b0);
        token(8'hE1, 7'h15);
        send_byte(8'h4B);
        send_hdr(63, 49, 1'b1);
        send_byte(8'hCC); send_byte(8'hDD);
        send_eop();
        chk("new_block_set", new_block, 1'b1);
        check_writes("chunk2");
        chk("load_perr", n_perr - b_perr, 0);

        // HASH rejected while a block is pending
        snap();
        token(8'hE1, 7'h15);
        send_byte(8'hC3); send_byte(8'h01);
        send_hdr(0, 3, 1'b0);
        send_eop();
        idle(2);
        chk("busy_perr", n_perr - b_perr, 1);
        chk("busy_held", new_block, 1'b1);
        check_writes("busy_writes");
        @(negedge clk); block_ack = 1'b1;
        @(negedge clk); block_ack = 1'b0;
        chk("block_ack_clear", new_block, 1'b0);

        // DATA1 without chunk1, DATA0 without OUT
        snap();
        token(8'hE1, 7'h15);
        send_byte(8'h4B);
        send_hdr(63, 4, 1'b0);
        send_eop();
        idle(2);
        chk("orphan_d1_perr", n_perr - b_perr, 1);
        send_byte(8'hC3); send_byte(8'h01);
        send_hdr(0, 4, 1'b0);
        send_eop();
        idle(2);
        chk("unarmed_d0_perr", n_perr - b_perr, 2);
        chk("orphan_no_block", new_block, 1'b0);
        check_writes("orphan_writes");

        // short chunk2: 48 payload + 2 CRC; first CRC byte lands at position 48
        snap();
        chunk1_full();
        token(8'hE1, 7'h15);
        send_byte(8'h4B);
        send_hdr(63, 48, 1'b1);
        send_byte(8'hEE); exp_q.push_back({7'd111, 8'hEE});
        send_byte(8'hEF);
        send_eop();
        idle(2);
        chk("short_c2_perr", n_perr - b_perr, 1);
        chk("short_c2_no_block", new_block, 1'b0);
        check_writes("short_c2");
        token(8'hE1, 7'h15);
        send_byte(8'h4B);
        send_hdr(63, 49, 1'b0);
        send_byte(8'hCC); send_byte(8'hDD);
        send_eop();
        idle(2);
        chk("c1_cleared_perr", n_perr - b_perr, 2);
        check_writes("c1_cleared");

        // rcv_error mid-chunk1
        snap();
        token(8'hE1, 7'h15);
        send_byte(8'hC3); send_byte(8'h01);
        send_hdr(0, 20, 1'b1);
        @(negedge clk); rcv_error = 1'b1;
        @(negedge clk); rcv_error = 1'b0;
        chk("rcv_err_latency", p_error, 1'b1);
        send_hdr(20, 43, 1'b0);
        send_byte(8'hAA); send_byte(8'hBB);
        send_eop();
        idle(2);
        chk("rcv_err_perr", n_perr - b_perr, 1);
        check_writes("rcv_err");

        // reset mid-chunk2, then a DATA1 must be rejected
        chunk1_full();
        token(8'hE1, 7'h15);
        send_byte(8'h4B);
        send_hdr(63, 10, 1'b1);
        check_writes("pre_reset");
        @(negedge clk); byte_valid = 1'b1; rx_byte = hdr(73); n_rst = 1'b0;
        @(negedge clk); byte_valid = 1'b0; n_rst = 1'b1;
        chk("mid_reset_outputs", {buf_wr_en, new_block, interrupt_req, in_token, p_error}, 5'b0);
        send_eop();
        snap();
        token(8'hE1, 7'h15);
        send_byte(8'h4B);
        send_hdr(63, 49, 1'b0);
        send_byte(8'hCC); send_byte(8'hDD);
        send_eop();
        idle(2);
        chk("post_reset_perr", n_perr - b_perr, 1);
        chk("post_reset_no_block", new_block, 1'b0);
        check_writes("post_reset");

        chk("pulse_exclusive", n_excl, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
